serial_transmitter: RTL and testbench
=====================================

SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1, clk cycles per serial bit; legal range 1..255.
REQ-002 Parameter STOP_BITS, default 1, number of high stop bits per frame; legal values 1 or 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 data_in  input  8  byte to transmit.
REQ-006 valid  input  1  data_in is valid; transfer occurs when valid && ready at a rising edge.
REQ-007 ready  output  1  holding register empty; ready = !hold_full, with no same-cycle bypass.
REQ-008 resend  input  1  single-cycle request to retransmit the last frame sent.
REQ-009 out  output  1  serial line; idles high.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.
REQ-011 frame_done  output  1  one-cycle pulse in the final cycle of the last stop bit.

Function
REQ-012 Frame format SHALL be: start bit 0, then d[0]..d[7] LSB first, then parity bit = XOR of d[7:0] (even parity), then STOP_BITS bits of 1.
REQ-013 Each bit SHALL be held on out for exactly CLKS_PER_BIT cycles, timed by a baud counter that restarts at every bit boundary.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-015 FSM transitions: IDLE->START on load; START->DATA; DATA->PARITY after bit index 7; PARITY->STOP; STOP->START on load at the end of the last stop bit, otherwise STOP->IDLE.
REQ-016 Accepted bytes SHALL go to a one-entry holding register; a load moves the hold contents to the shift register and to last_frame, and clears hold_full.
REQ-017 A load SHALL occur in IDLE, or at the end of the last stop bit, when hold_full or resend_pending is set.
REQ-018 Latency: for a byte accepted at edge N with the FSM in IDLE, out SHALL go 0 after edge N+1.
REQ-019 Back-to-back frames SHALL have no idle gap; the start bit immediately follows the last stop bit.
REQ-020 A resend pulse SHALL set resend_pending, provided at least one frame has been sent since reset; otherwise it is ignored.
REQ-021 resend_pending SHALL take priority over hold_full at a load; it reloads last_frame and clears resend_pending, leaving hold untouched.
REQ-022 Multiple resend pulses before a load SHALL collapse into one retransmission.
REQ-023 resend coincident with frame_done SHALL cause the retransmission to start at that same load point.
REQ-024 valid while ready=0 SHALL be ignored; data_in is sampled only on a transfer.
REQ-025 out SHALL be registered, with no combinational path from any input.

Reset
REQ-026 rst_n low SHALL immediately force: out=1, ready=1, busy=0, frame_done=0, FSM=IDLE.
REQ-027 rst_n low SHALL also clear hold_full, resend_pending, the sent-flag and all counters.
REQ-028 Reset mid-frame SHALL abort the frame with no completion; the line returns high at once.
REQ-029 After rst_n deasserts, the first transfer SHALL be accepted on the first rising edge with valid high.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the frame-length constant (1+8+1 data-side bits) and the IDLE_LEVEL=1 constant; the downstream receiver uses the same package.
REQ-031 The baud counter SHALL be a sub-module, baud_tick_gen, producing a bit-end strobe every CLKS_PER_BIT cycles while enabled.

Verification
REQ-032 Send 0xA5 (CLKS_PER_BIT=1, STOP_BITS=1) -> out = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; frame_done in cycle 11.
REQ-033 Send 0x07 -> parity bit 1; full sequence 0,1,1,1,0,0,0,0,0,1,1.
REQ-034 Hold valid with 0x01 then 0x80 -> ready drops after the second accept; the second start bit immediately follows the first stop bit; total 22 busy cycles.
REQ-035 Pulse resend during the frame for 0x3C, with 0x55 in hold -> 0x3C is transmitted again, then 0x55.
REQ-036 Assert rst_n low at bit index 4 of a frame -> out=1 and busy=0 asynchronously; no frame_done pulse; the next byte transmits correctly.
REQ-037 Run with CLKS_PER_BIT=4, STOP_BITS=2 and 0xA5 -> each bit lasts 4 cycles; frame lasts 48 cycles.

Source files
------------

// File: rtl/serial_transmitter_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver.
package serial_transmitter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int unsigned DATA_BITS  = 8;
  // Data-side bits of a frame: start + data + parity (stop bits excluded).
  localparam int unsigned FRAME_BITS = 1 + DATA_BITS + 1;
  localparam logic        IDLE_LEVEL = 1'b1;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_transmitter_baud_tick_gen.sv
// Bit timer: strobes at the last cycle of every CLKS_PER_BIT-cycle bit period.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick_c,
  output logic pre_tick_c
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt;

  // Counter restarts whenever disabled or at each bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // tick_c: this cycle ends a bit; pre_tick_c: next cycle will end a bit.
  always_comb begin
    tick_c = en && (cnt == CNT_W'(CLKS_PER_BIT - 32'd1));
    if (CLKS_PER_BIT == 32'd1) begin
      pre_tick_c = 1'b1;
    end else begin
      pre_tick_c = en && (cnt == CNT_W'(CLKS_PER_BIT - 32'd2));
    end
  end

endmodule

// File: rtl/serial_transmitter.sv
// UART-style byte transmitter with one-entry holding register and frame resend.
module serial_transmitter
  import serial_transmitter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  input  logic       resend,
  output logic       out,
  output logic       busy,
  output logic       frame_done
);

  tx_state_t            state, state_d;
  logic [DATA_BITS-1:0] hold, hold_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [DATA_BITS-1:0] last_frame, last_frame_d;
  logic                 hold_full, hold_full_d;
  logic                 resend_pending, resend_pending_d;
  logic                 sent, sent_d;
  logic [2:0]           bit_idx, bit_idx_d;
  logic                 stop_idx, stop_idx_d;
  logic                 out_d, ready_d, busy_d, frame_done_d;

  logic tick_c, pre_tick_c;
  logic accept_c, resend_req_c, load_c;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state != IDLE),
    .tick_c     (tick_c),
    .pre_tick_c (pre_tick_c)
  );

  // Next-state and next-output logic; every register value is decided here.
  always_comb begin
    state_d          = state;
    hold_d           = hold;
    shift_d          = shift;
    last_frame_d     = last_frame;
    hold_full_d      = hold_full;
    resend_pending_d = resend_pending;
    sent_d           = sent;
    bit_idx_d        = bit_idx;
    stop_idx_d       = stop_idx;
    out_d            = out;
    load_c           = 1'b0;

    accept_c     = valid && ready;
    // A resend arriving right at a load point is honoured at that load.
    resend_req_c = resend_pending || (resend && sent);

    if (resend && sent) begin
      resend_pending_d = 1'b1;
    end

    case (state)
      IDLE: begin
        if (hold_full || resend_req_c) begin
          load_c = 1'b1;
        end
      end
      START: begin
        if (tick_c) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          out_d     = shift[0];
        end
      end
      DATA: begin
        if (tick_c) begin
          if (bit_idx == 3'd7) begin
            state_d = PARITY;
            out_d   = even_parity(last_frame);
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shift_d   = shift >> 1;
            out_d     = shift[1];
          end
        end
      end
      PARITY: begin
        if (tick_c) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
          out_d      = IDLE_LEVEL;
        end
      end
      STOP: begin
        if (tick_c) begin
          if (stop_idx == 1'(STOP_BITS - 32'd1)) begin
            if (hold_full || resend_req_c) begin
              load_c = 1'b1;
            end else begin
              state_d = IDLE;
              out_d   = IDLE_LEVEL;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = IDLE_LEVEL;
      end
    endcase

    // Load: a pending resend wins and leaves the holding register alone.
    if (load_c) begin
      state_d = START;
      out_d   = ~IDLE_LEVEL;
      sent_d  = 1'b1;
      if (resend_req_c) begin
        shift_d          = last_frame;
        resend_pending_d = 1'b0;
      end else begin
        shift_d      = hold;
        last_frame_d = hold;
        hold_full_d  = 1'b0;
      end
    end

    // Accept never coincides with a load from hold (hold is full then).
    if (accept_c) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    ready_d      = !hold_full_d;
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == STOP) &&
                   (stop_idx_d == 1'(STOP_BITS - 32'd1)) && pre_tick_c;
  end

  // State and output registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      hold           <= '0;
      shift          <= '0;
      last_frame     <= '0;
      hold_full      <= 1'b0;
      resend_pending <= 1'b0;
      sent           <= 1'b0;
      bit_idx        <= 3'd0;
      stop_idx       <= 1'b0;
      out            <= IDLE_LEVEL;
      ready          <= 1'b1;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_d;
      hold           <= hold_d;
      shift          <= shift_d;
      last_frame     <= last_frame_d;
      hold_full      <= hold_full_d;
      resend_pending <= resend_pending_d;
      sent           <= sent_d;
      bit_idx        <= bit_idx_d;
      stop_idx       <= stop_idx_d;
      out            <= out_d;
      ready          <= ready_d;
      busy           <= busy_d;
      frame_done     <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed self-checking bench for serial_transmitter (two parameterisations).
module tb_serial_transmitter;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, a_resend, b_resend;
  logic       a_ready, b_ready, a_out, b_out, a_busy, b_busy, a_done, b_done;

  int n_chk;
  int n_pass;

  serial_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_data), .valid(a_valid), .ready(a_ready),
    .resend(a_resend), .out(a_out), .busy(a_busy), .frame_done(a_done)
  );

  serial_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_data), .valid(b_valid), .ready(b_ready),
    .resend(b_resend), .out(b_out), .busy(b_busy), .frame_done(b_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Frame as transmitted, bit 0 first: start, data LSB first, even parity, stop.
  function automatic logic [10:0] frame11(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  // Set bits [from, n) to the idle level.
  function automatic logic [63:0] idle_fill(input logic [63:0] v, input int from, input int n);
    logic [63:0] r;
    r = v;
    for (int i = from; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Sample dut_a once per cycle on the falling edge, optionally pulsing resend / dropping valid.
  task automatic run_a(input int n, input int rs1, input int rs2, input int vdrop,
                       output logic [63:0] o, output logic [63:0] d,
                       output logic [63:0] r, output int bc);
    o = '0; d = '0; r = '0; bc = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      o[k] = a_out;
      d[k] = a_done;
      r[k] = a_ready;
      if (a_busy) bc++;
      a_resend = (k == rs1) || (k == rs2);
      if (k == vdrop) a_valid = 1'b0;
    end
    a_resend = 1'b0;
  endtask

  logic [63:0] o, d, r, e;
  int          bc;
  logic [11:0] f12;

  initial begin
    n_chk = 0; n_pass = 0;
    a_data = '0; a_valid = 0; a_resend = 0;
    b_data = '0; b_valid = 0; b_resend = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out", a_out, 1);
    chk("rst_ready", a_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Resend with nothing sent since reset is ignored.
    run_a(6, 0, -1, -1, o, d, r, bc);
    chk("resend_ignored_busy", 64'(bc), 0);
    chk("resend_ignored_out", o, 64'h3f);

    // 0xA5: single frame, latency and frame_done position.
    @(negedge clk); a_valid = 1; a_data = 8'hA5;
    @(negedge clk); chk("a5_ready_drop", a_ready, 0); a_valid = 0;
    run_a(14, -1, -1, -1, o, d, r, bc);
    chk("a5_latency", o[0], 0);
    chk("a5_bits", o, idle_fill(64'b10101001010, 11, 14));
    chk("a5_done", d, 64'h400);
    chk("a5_busy", 64'(bc), 11);

    // 0x07 with resend coinciding with frame_done: retransmitted back-to-back.
    @(negedge clk); a_valid = 1; a_data = 8'h07;
    @(negedge clk); a_valid = 0;
    run_a(25, 10, -1, -1, o, d, r, bc);
    chk("07_bits", o, idle_fill({42'b0, 11'b11000001110, 11'b11000001110}, 22, 25));
    chk("07_done", d, (64'd1 << 10) | (64'd1 << 21));
    chk("07_busy", 64'(bc), 22);

    // Streaming 0x01 then 0x80 with valid held.
    @(negedge clk); a_valid = 1; a_data = 8'h01;
    @(negedge clk); chk("b2b_ready_first", a_ready, 0); a_data = 8'h80;
    run_a(30, -1, -1, 1, o, d, r, bc);
    chk("b2b_ready", r[11:0], 12'h801);
    chk("b2b_bits", o, idle_fill({42'b0, frame11(8'h80), frame11(8'h01)}, 22, 30));
    chk("b2b_busy", 64'(bc), 22);

    // 0x3C in flight, 0x55 held, two resend pulses collapse into one retransmission.
    @(negedge clk); a_valid = 1; a_data = 8'h3C;
    @(negedge clk); a_data = 8'h55;
    run_a(40, 3, 6, 1, o, d, r, bc);
    chk("resend_bits", o,
        idle_fill({31'b0, frame11(8'h55), frame11(8'h3C), frame11(8'h3C)}, 33, 40));
    chk("resend_done", d, (64'd1 << 10) | (64'd1 << 21) | (64'd1 << 32));
    chk("resend_busy", 64'(bc), 33);

    // Reset at data bit index 4 of a 0x00 frame.
    @(negedge clk); a_valid = 1; a_data = 8'h00;
    @(negedge clk); a_valid = 0;
    repeat (6) @(negedge clk);
    chk("mid_pre_out", a_out, 0);
    chk("mid_pre_busy", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", a_out, 1);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_ready", a_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    run_a(12, -1, -1, -1, o, d, r, bc);
    chk("mid_no_done", d, 0);
    chk("mid_idle_busy", 64'(bc), 0);
    a_valid = 1; a_data = 8'h5A;
    @(negedge clk); a_valid = 0;
    run_a(13, -1, -1, -1, o, d, r, bc);
    chk("post_rst_bits", o, idle_fill({53'b0, frame11(8'h5A)}, 11, 13));
    chk("post_rst_done", d, 64'h400);

    // CLKS_PER_BIT=4, STOP_BITS=2: each bit 4 cycles, 48-cycle frame.
    @(negedge clk); b_valid = 1; b_data = 8'hA5;
    @(negedge clk); b_valid = 0;
    f12 = {2'b11, 1'b0, 8'hA5, 1'b0};
    e = '0;
    for (int j = 0; j < 48; j++) e[j] = f12[j / 4];
    e = idle_fill(e, 48, 52);
    o = '0; d = '0; bc = 0;
    for (int k = 0; k < 52; k++) begin
      @(negedge clk);
      o[k] = b_out;
      d[k] = b_done;
      if (b_busy) bc++;
    end
    chk("slow_bits", o, e);
    chk("slow_done", d, 64'd1 << 47);
    chk("slow_busy", 64'(bc), 48);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
